// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - two-street traffic light scheduler with pedestrian walk service
//
// Ports:
//   clk            single clock, all state changes on its rising edge
//   rst            asynchronous active-low reset
//   TA, TB         traffic-present sensors for street A / street B
//   PED_A, PED_B   pedestrian request pulses for phase A / phase B
//   RA, YA, GA     street A red / yellow / green lamps
//   RB, YB, GB     street B red / yellow / green lamps
//   WALK_A, WALK_B pedestrian walk indication for phase A / phase B
//   STATE          current FSM state code (debug)
module intersection_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TA,
  input  logic       TB,
  input  logic       PED_A,
  input  logic       PED_B,
  output logic       RA,
  output logic       YA,
  output logic       GA,
  output logic       RB,
  output logic       YB,
  output logic       GB,
  output logic       WALK_A,
  output logic       WALK_B,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_GA  = 3'd0,
    S_YA  = 3'd1,
    S_RR1 = 3'd2,
    S_GB  = 3'd3,
    S_YB  = 3'd4,
    S_RR2 = 3'd5
  } state_t;

  localparam logic [3:0] GMIN    = 4'(GREEN_MIN);
  localparam logic [3:0] GMIN_M1 = 4'(GREEN_MIN - 1);
  localparam logic [3:0] GMAX_M1 = 4'(GREEN_MAX - 1);
  localparam logic [3:0] YEL_M1  = 4'(YELLOW_T - 1);
  localparam logic [3:0] AR_M1   = 4'(ALL_RED_T - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] t;
  logic       pend_a;
  logic       pend_b;
  logic       walk_flag_a;
  logic       walk_flag_b;
  logic       demand_a;
  logic       demand_b;
  logic       enter_ga;
  logic       enter_gb;

  assign demand_a = TA | pend_a;
  assign demand_b = TB | pend_b;

  always_comb begin
    state_next = state;
    case (state)
      // A green yields only after the minimum dwell, only if B wants service,
      // and, while A still has traffic, only once the maximum dwell is reached.
      S_GA:  if (t >= GMIN_M1 && demand_b && (!TA || t >= GMAX_M1)) state_next = S_YA;
      S_YA:  if (t == YEL_M1) state_next = S_RR1;
      S_RR1: if (t == AR_M1) state_next = S_GB;
      S_GB:  if (t >= GMIN_M1 && demand_a && (!TB || t >= GMAX_M1)) state_next = S_YB;
      S_YB:  if (t == YEL_M1) state_next = S_RR2;
      S_RR2: if (t == AR_M1) state_next = S_GA;
      default: state_next = S_GA;
    endcase
  end

  assign enter_ga = (state_next == S_GA) && (state != S_GA);
  assign enter_gb = (state_next == S_GB) && (state != S_GB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_GA;
      t           <= 4'd0;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      walk_flag_a <= 1'b0;
      walk_flag_b <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        t <= 4'd0;
      end else if (t != 4'hF) begin
        t <= t + 4'd1;
      end
      // A request arriving on the entry edge is served by this green, so it
      // feeds the walk flag directly and never lands in the pending flag.
      if (enter_ga) begin
        pend_a      <= 1'b0;
        walk_flag_a <= pend_a | PED_A;
      end else if (PED_A) begin
        pend_a <= 1'b1;
      end
      if (enter_gb) begin
        pend_b      <= 1'b0;
        walk_flag_b <= pend_b | PED_B;
      end else if (PED_B) begin
        pend_b <= 1'b1;
      end
    end
  end

  always_comb begin
    RA = 1'b0;
    YA = 1'b0;
    GA = 1'b0;
    RB = 1'b0;
    YB = 1'b0;
    GB = 1'b0;
    case (state)
      S_GA: begin GA = 1'b1; RB = 1'b1; end
      S_YA: begin YA = 1'b1; RB = 1'b1; end
      S_GB: begin RA = 1'b1; GB = 1'b1; end
      S_YB: begin RA = 1'b1; YB = 1'b1; end
      default: begin RA = 1'b1; RB = 1'b1; end
    endcase
  end

  assign WALK_A = (state == S_GA) && walk_flag_a && (t < GMIN);
  assign WALK_B = (state == S_GB) && walk_flag_b && (t < GMIN);
  assign STATE  = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - self-checking bench for intersection_scheduler
module tb_intersection_scheduler;

  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int YEL  = 2;
  localparam int AR   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       TA = 1'b0, TB = 1'b0, PED_A = 1'b0, PED_B = 1'b0;
  logic       RA, YA, GA, RB, YB, GB, WALK_A, WALK_B;
  logic [2:0] STATE;

  int total = 0;
  int bad   = 0;

  // reference model: phase index around the 6-phase cycle and cycles spent in it
  int m_p   = 0;
  int m_cnt = 0;
  bit m_pa = 0, m_pb = 0, m_wa = 0, m_wb = 0;

  intersection_scheduler #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL), .ALL_RED_T(AR)
  ) dut (
    .clk(clk), .rst(rst), .TA(TA), .TB(TB), .PED_A(PED_A), .PED_B(PED_B),
    .RA(RA), .YA(YA), .GA(GA), .RB(RB), .YB(YB), .GB(GB),
    .WALK_A(WALK_A), .WALK_B(WALK_B), .STATE(STATE)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // {RA,YA,GA,RB,YB,GB} for each phase
  function automatic logic [5:0] lamps_of(int p);
    case (p)
      0: return 6'b001100;
      1: return 6'b010100;
      3: return 6'b100001;
      4: return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  task automatic model_reset();
    m_p = 0; m_cnt = 0; m_pa = 0; m_pb = 0; m_wa = 0; m_wb = 0;
  endtask

  task automatic model_step(bit ta, bit tb, bit ped_a, bit ped_b);
    bit leave;
    bit dem_a = ta | m_pa;
    bit dem_b = tb | m_pb;
    case (m_p)
      0: leave = (m_cnt >= GMIN - 1) && dem_b && (!ta || m_cnt >= GMAX - 1);
      3: leave = (m_cnt >= GMIN - 1) && dem_a && (!tb || m_cnt >= GMAX - 1);
      1, 4: leave = (m_cnt == YEL - 1);
      default: leave = (m_cnt == AR - 1);
    endcase
    if (leave && m_p == 5) begin m_wa = m_pa | ped_a; m_pa = 0; end
    else if (ped_a) m_pa = 1;
    if (leave && m_p == 2) begin m_wb = m_pb | ped_b; m_pb = 0; end
    else if (ped_b) m_pb = 1;
    if (leave) begin m_p = (m_p + 1) % 6; m_cnt = 0; end
    else m_cnt++;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    logic [10:0] obs, exp;
    logic        wa, wb, sane;
    wa  = (m_p == 0) && m_wa && (m_cnt < GMIN);
    wb  = (m_p == 3) && m_wb && (m_cnt < GMIN);
    obs = {RA, YA, GA, RB, YB, GB, WALK_A, WALK_B, STATE};
    exp = {lamps_of(m_p), wa, wb, 3'(m_p)};
    check({tag, "_model"}, 32'(obs), 32'(exp));
    sane = (32'(RA) + 32'(YA) + 32'(GA) == 1) && (32'(RB) + 32'(YB) + 32'(GB) == 1) && (RA || RB);
    check({tag, "_lamp_rule"}, 32'(sane), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step(TA, TB, PED_A, PED_B);
    #1;
  endtask

  task automatic run(int n, string tag);
    for (int i = 0; i < n; i++) begin
      check_outputs(tag);
      tick();
    end
  endtask

  // asynchronous reset taken mid-cycle: outputs must settle before the next edge
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("reset_async", 32'({RA, YA, GA, RB, YB, GB, WALK_A, WALK_B, STATE}),
          32'(11'b001100_00_000));
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int k;
    logic [2:0] es;

    // power-on reset
    tick();
    check("reset_vec", 32'({RA, YA, GA, RB, YB, GB, WALK_A, WALK_B, STATE}),
          32'(11'b001100_00_000));
    rst = 1'b1;

    // B traffic only: GA 0-3, YA 4-5, all-red 6, GB from 7
    TA = 0; TB = 1;
    for (int c = 0; c < 12; c++) begin
      es = (c < 4) ? 3'd0 : (c < 6) ? 3'd1 : (c == 6) ? 3'd2 : 3'd3;
      check("b_only_state", 32'(STATE), 32'(es));
      check_outputs("b_only");
      tick();
    end

    // reset taken while in GB
    do_reset();

    // full contention: 30-cycle alternation with GREEN_MAX greens
    TA = 1; TB = 1;
    for (int c = 0; c < 65; c++) begin
      k  = c % 30;
      es = (k < 12) ? 3'd0 : (k < 14) ? 3'd1 : (k == 14) ? 3'd2 :
           (k < 27) ? 3'd3 : (k < 29) ? 3'd4 : 3'd5;
      check("contention_state", 32'(STATE), 32'(es));
      check_outputs("contention");
      tick();
    end

    // no traffic: A green forever, no walk
    do_reset();
    TA = 0; TB = 0;
    for (int c = 0; c < 100; c++) begin
      check("idle_hold", 32'({STATE, WALK_A}), 32'(4'b0000));
      check_outputs("idle");
      tick();
    end

    // pedestrian B pulse at cycle 1
    do_reset();
    TA = 0; TB = 0;
    for (int c = 0; c < 15; c++) begin
      PED_B = (c == 1);
      es = (c < 4) ? 3'd0 : (c < 6) ? 3'd1 : (c == 6) ? 3'd2 : 3'd3;
      check("ped_b_state", 32'(STATE), 32'(es));
      check("ped_b_walk", 32'(WALK_B), 32'((c >= 7) && (c <= 10)));
      check_outputs("ped_b");
      tick();
    end
    PED_B = 0;
    check("ped_b_served", 32'(dut.pend_b), 32'd0);

    // reset during YB with a pending A request
    do_reset();
    TA = 0; TB = 1;
    k = 0;
    while (STATE !== 3'd3 && k < 20) begin check_outputs("to_gb"); tick(); k++; end
    check("wait_gb", 32'(STATE), 32'd3);
    PED_A = 1;
    run(1, "ped_a_pulse");
    PED_A = 0;
    k = 0;
    while (STATE !== 3'd4 && k < 30) begin check_outputs("to_yb"); tick(); k++; end
    check("wait_yb", 32'(STATE), 32'd4);
    check("pend_a_set", 32'(dut.pend_a), 32'd1);
    do_reset();
    TB = 0;
    for (int c = 0; c < 6; c++) begin
      check("no_walk_after_reset", 32'(WALK_A), 32'd0);
      check_outputs("post_reset");
      tick();
    end

    // randomized traffic, pedestrian pulses and occasional resets
    for (int c = 0; c < 2000; c++) begin
      if (c % 50 == 0) begin
        k = $urandom_range(0, 3);
      end
      TA    = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      TB    = (k == 0) ? 1'b0 : (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      PED_A = ($urandom_range(0, 15) == 0);
      PED_B = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else run(1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
